// File: rtl/apb_i2c_xfer_master.sv
// APB master that drives one I2C transfer through the apb_to_i2c_top register map:
// init, address, TX fill, start, status polling, RX drain, stop, then done/err.
module apb_i2c_xfer_master #(
    parameter int unsigned             ADDRESSWIDTH = 4,
    parameter int unsigned             DATAWIDTH    = 8,
    parameter int unsigned             LENW         = 8,
    parameter int unsigned             TIMEOUT      = 1024,
    parameter logic [ADDRESSWIDTH-1:0] A_CMD        = ADDRESSWIDTH'(0),
    parameter logic [ADDRESSWIDTH-1:0] A_STAT       = ADDRESSWIDTH'(1),
    parameter logic [ADDRESSWIDTH-1:0] A_TX         = ADDRESSWIDTH'(2),
    parameter logic [ADDRESSWIDTH-1:0] A_RX         = ADDRESSWIDTH'(3),
    parameter logic [ADDRESSWIDTH-1:0] A_ADDR       = ADDRESSWIDTH'(4)
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [6:0]              req_addr,
    input  logic                    req_rw,
    input  logic [LENW-1:0]         req_len,
    input  logic [7:0]              wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    done,
    output logic                    err,
    output logic [ADDRESSWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0]    PWDATA,
    output logic                    PWRITE,
    output logic                    PSELx,
    output logic                    PENABLE,
    input  logic [DATAWIDTH-1:0]    PRDATA,
    input  logic                    PREADY
);
    localparam int unsigned          PW       = $clog2(TIMEOUT + 1);
    localparam logic [DATAWIDTH-1:0] CMD_INIT = DATAWIDTH'(8'hF8);
    localparam logic [DATAWIDTH-1:0] CMD_GO   = DATAWIDTH'(8'hFC);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_SETADDR, S_TXPOLL, S_TXWR, S_START,
        S_WBUSY, S_RUN, S_RXRD, S_DRAIN, S_STOP, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

    state_t          r_state, w_state_nxt;
    phase_t          r_phase, w_phase_nxt;
    logic [6:0]      r_addr7;
    logic            r_rw;
    logic [LENW-1:0] r_len, r_cnt;
    logic [PW-1:0]   r_poll;
    logic            r_err;
    logic [7:0]      r_txbyte, r_rd_data;
    logic            r_rd_valid;

    logic w_xfer, w_poll, w_poll_to, w_short, w_rx_take, w_active;

    assign w_xfer    = (r_phase == PH_ACCESS) && PREADY;
    assign w_poll_to = (r_poll == PW'(TIMEOUT - 1));
    assign w_rx_take = r_rw && !PRDATA[4] && (r_cnt != r_len);
    assign w_active  = (r_state != S_IDLE) && (r_state != S_DONE);

    assign req_ready = (r_state == S_IDLE);
    assign wr_ready  = (r_state == S_TXWR) && w_xfer;
    assign done      = (r_state == S_DONE);
    assign err       = done && r_err;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign PSELx     = (r_phase != PH_IDLE);
    assign PENABLE   = (r_phase == PH_ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_phase <= PH_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_poll      = 1'b0;
        w_short     = 1'b0;
        case (r_state)
            S_IDLE:    if (req_valid) w_state_nxt = S_INIT;
            S_INIT:    if (w_xfer) w_state_nxt = S_SETADDR;
            S_SETADDR: if (w_xfer) w_state_nxt = (!r_rw && r_len != '0) ? S_TXPOLL : S_START;
            S_TXPOLL:  if (w_xfer) begin
                if (!PRDATA[7] && wr_valid) w_state_nxt = S_TXWR;
                else                        w_poll      = 1'b1;
            end
            S_TXWR:    if (w_xfer) w_state_nxt = (r_cnt + LENW'(1) == r_len) ? S_START : S_TXPOLL;
            S_START:   if (w_xfer) w_state_nxt = S_WBUSY;
            S_WBUSY:   if (w_xfer) begin
                if (!PRDATA[3]) w_state_nxt = S_RUN;
                else            w_poll      = 1'b1;
            end
            S_RUN:     if (w_xfer) begin
                if (w_rx_take)     w_state_nxt = S_RXRD;
                else if (PRDATA[3]) w_state_nxt = S_DRAIN;
                else                w_poll      = 1'b1;
            end
            S_RXRD:    if (w_xfer) w_state_nxt = S_RUN;
            S_DRAIN:   if (w_xfer) begin
                if (w_rx_take) w_state_nxt = S_RXRD;
                else begin
                    w_state_nxt = S_STOP;
                    w_short     = (r_cnt != r_len);
                end
            end
            S_STOP:    if (w_xfer) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_poll && w_poll_to) w_state_nxt = S_STOP;
    end

    // A pending read byte holds off the next access so RX data is never overwritten.
    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            PH_IDLE:   if (w_active && !r_rd_valid) w_phase_nxt = PH_SETUP;
            PH_SETUP:  w_phase_nxt = PH_ACCESS;
            PH_ACCESS: if (PREADY) w_phase_nxt = PH_IDLE;
            default:   w_phase_nxt = PH_IDLE;
        endcase
    end

    always_comb begin
        PWRITE = 1'b0;
        PADDR  = '0;
        PWDATA = '0;
        if (PSELx) begin
            case (r_state)
                S_INIT, S_STOP: begin PWRITE = 1'b1; PADDR = A_CMD; PWDATA = CMD_INIT; end
                S_SETADDR: begin PWRITE = 1'b1; PADDR = A_ADDR; PWDATA = DATAWIDTH'({r_addr7, r_rw}); end
                S_TXWR:    begin PWRITE = 1'b1; PADDR = A_TX;   PWDATA = DATAWIDTH'(r_txbyte); end
                S_START:   begin PWRITE = 1'b1; PADDR = A_CMD;  PWDATA = CMD_GO; end
                S_RXRD:    PADDR = A_RX;
                default:   PADDR = A_STAT;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_addr7    <= '0;
            r_rw       <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_poll     <= '0;
            r_err      <= 1'b0;
            r_txbyte   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_addr7 <= req_addr;
                r_rw    <= req_rw;
                r_len   <= req_len;
                r_cnt   <= '0;
                r_poll  <= '0;
                r_err   <= 1'b0;
            end
            if (w_xfer) r_poll <= (w_poll && !w_poll_to) ? r_poll + PW'(1) : '0;
            if ((w_poll && w_poll_to) || w_short) r_err <= 1'b1;
            if (r_state == S_TXPOLL && w_state_nxt == S_TXWR) r_txbyte <= wr_data;
            if ((r_state == S_TXWR || r_state == S_RXRD) && w_xfer) r_cnt <= r_cnt + LENW'(1);
            if (r_state == S_RXRD && w_xfer) begin
                r_rd_data  <= PRDATA[7:0];
                r_rd_valid <= 1'b1;
            end else if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb_i2c_xfer_master.sv
// Directed bench for apb_i2c_xfer_master against a small behavioural APB/I2C register model.
module tb_apb_i2c_xfer_master;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       req_valid = 1'b0, req_rw = 1'b0, req_ready;
    logic [6:0] req_addr = '0;
    logic [7:0] req_len = '0;
    logic [7:0] wr_data = '0, rd_data;
    logic       wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b1, done, err;
    logic [3:0] PADDR;
    logic [7:0] PWDATA, PRDATA = '0;
    logic       PWRITE, PSELx, PENABLE, PREADY = 1'b0;

    int   n_cmp = 0, n_bad = 0;
    int   wtrace[$];
    logic [7:0] rd_got[$], wr_q[$], tx_q[$], rx_src[$], rx_q[$];
    int   busy = 0, busy_cfg = 3, pready_delay = 0, wcnt = 0, stab_bad = 0;
    int   stat_after_go = 0, n_done = 0, n_wr_pulses = 0;
    logic last_err = 1'b0, rd_stall = 1'b0, go_seen = 1'b0;
    logic [3:0] sv_addr;
    logic [7:0] sv_data;
    logic       sv_wr;

    apb_i2c_xfer_master #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial forever #5 PCLK = ~PCLK;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slave_access();
        logic [7:0] st;
        if (PWRITE) begin
            wtrace.push_back((int'(PADDR) << 8) | int'(PWDATA));
            if (PADDR == 4'd0 && PWDATA[2]) begin
                busy = busy_cfg; rx_q = rx_src; stat_after_go = 0; go_seen = 1'b1;
            end
            if (PADDR == 4'd2) tx_q.push_back(PWDATA);
            PRDATA = '0;
        end else if (PADDR == 4'd1) begin
            st = {(tx_q.size() >= 8), (tx_q.size() == 0), 1'b0, (rx_q.size() == 0), (busy == 0), 3'b000};
            if (busy > 0) busy--;
            stat_after_go++;
            PRDATA = st;
        end else if (PADDR == 4'd3 && rx_q.size() > 0) begin
            PRDATA = rx_q.pop_front();
        end else begin
            PRDATA = '0;
        end
    endtask

    // Slave: wait states counted in ACCESS; request lines must hold while PREADY is low.
    initial forever begin
        @(negedge PCLK);
        if (PSELx && PENABLE) begin
            if (wcnt == 0) begin sv_addr = PADDR; sv_wr = PWRITE; sv_data = PWDATA; end
            else if (PADDR != sv_addr || PWRITE != sv_wr || PWDATA != sv_data) stab_bad++;
            if (wcnt >= pready_delay) begin PREADY = 1'b1; slave_access(); end
            else PREADY = 1'b0;
            wcnt++;
        end else begin
            PREADY = 1'b0; PRDATA = '0; wcnt = 0;
        end
    end

    initial begin
        logic f;
        forever begin
            @(negedge PCLK); #1;
            f = wr_ready;
            if (rd_valid && rd_ready) rd_got.push_back(rd_data);
            if (done) begin n_done++; last_err = err; end
            @(posedge PCLK); #1;
            if (f) begin
                n_wr_pulses++;
                if (wr_q.size() > 0) void'(wr_q.pop_front());
            end
            wr_valid = (wr_q.size() > 0);
            wr_data  = wr_valid ? wr_q[0] : 8'h00;
            rd_ready = rd_stall ? ~rd_ready : 1'b1;
        end
    end

    task automatic clear_tb();
        wtrace.delete(); rd_got.delete(); tx_q.delete(); rx_q.delete(); rx_src.delete();
        n_wr_pulses = 0; busy = 0; go_seen = 1'b0;
    endtask

    task automatic send_req(input logic [6:0] a, input logic rw, input logic [7:0] len);
        int k = 0;
        @(posedge PCLK); #1;
        while (!req_ready && k < 100) begin @(posedge PCLK); #1; k++; end
        check("req_ready_idle", int'(req_ready), 1);
        req_addr = a; req_rw = rw; req_len = len; req_valid = 1'b1;
        @(posedge PCLK); #1;
        req_valid = 1'b0; req_addr = 7'h7F; req_rw = ~rw; req_len = 8'hFF;
        check("req_taken", int'(req_ready), 0);
    endtask

    task automatic wait_done(input string tag, output logic e);
        int start = n_done;
        int k = 0;
        while (n_done == start && k < 3000) begin @(posedge PCLK); k++; end
        check({tag, "_done_seen"}, int'(n_done != start), 1);
        e = last_err;
    endtask

    task automatic check_trace(input string tag, input int exp_q[$]);
        check({tag, "_trace_len"}, wtrace.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wtrace.size(); i++)
            check($sformatf("%s_w%0d", tag, i), wtrace[i], exp_q[i]);
    endtask

    initial begin
        logic e;
        int   exp_q[$];
        int   k;
        int   nd;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_psel", PSELx, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_data", rd_data, 0);
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;

        // write 3 bytes to 0x50
        clear_tb(); busy_cfg = 3; wr_q = '{8'hA1, 8'hB2, 8'hC3};
        send_req(7'h50, 1'b0, 8'd3);
        wait_done("t1", e);
        check("t1_err", e, 0);
        exp_q = '{'h0F8, 'h4A0, 'h2A1, 'h2B2, 'h2C3, 'h0FC, 'h0F8};
        check_trace("t1", exp_q);
        check("t1_wr_pulses", n_wr_pulses, 3);

        // read 2 bytes with a stalling consumer
        clear_tb(); busy_cfg = 3; rx_src = '{8'h5A, 8'hA5}; rd_stall = 1'b1;
        send_req(7'h50, 1'b1, 8'd2);
        wait_done("t2", e);
        rd_stall = 1'b0;
        check("t2_err", e, 0);
        check("t2_rd_count", rd_got.size(), 2);
        if (rd_got.size() == 2) begin
            check("t2_rd0", rd_got[0], 'h5A);
            check("t2_rd1", rd_got[1], 'hA5);
        end
        exp_q = '{'h0F8, 'h4A1, 'h0FC, 'h0F8};
        check_trace("t2", exp_q);

        // five wait states on every access
        clear_tb(); busy_cfg = 3; pready_delay = 5; stab_bad = 0;
        wr_q = '{8'hA1, 8'hB2, 8'hC3};
        send_req(7'h50, 1'b0, 8'd3);
        wait_done("t3", e);
        pready_delay = 0;
        check("t3_err", e, 0);
        check("t3_stable", stab_bad, 0);
        exp_q = '{'h0F8, 'h4A0, 'h2A1, 'h2B2, 'h2C3, 'h0FC, 'h0F8};
        check_trace("t3", exp_q);
        check("t3_wr_pulses", n_wr_pulses, 3);

        // short read: only one byte before the bus goes idle
        clear_tb(); busy_cfg = 3; rx_src = '{8'h77};
        send_req(7'h50, 1'b1, 8'd2);
        wait_done("t4", e);
        check("t4_err", e, 1);
        check("t4_rd_count", rd_got.size(), 1);
        if (rd_got.size() == 1) check("t4_rd0", rd_got[0], 'h77);
        exp_q = '{'h0F8, 'h4A1, 'h0FC, 'h0F8};
        check_trace("t4", exp_q);

        // i2c_ready never drops: poll timeout
        clear_tb(); busy_cfg = 0;
        send_req(7'h50, 1'b1, 8'd1);
        wait_done("t5", e);
        check("t5_err", e, 1);
        check("t5_polls", stat_after_go, 16);
        check("t5_rd_count", rd_got.size(), 0);
        exp_q = '{'h0F8, 'h4A1, 'h0FC, 'h0F8};
        check_trace("t5", exp_q);

        // address-only write
        clear_tb(); busy_cfg = 3;
        send_req(7'h50, 1'b0, 8'd0);
        wait_done("t7", e);
        check("t7_err", e, 0);
        check("t7_wr_pulses", n_wr_pulses, 0);
        exp_q = '{'h0F8, 'h4A0, 'h0FC, 'h0F8};
        check_trace("t7", exp_q);

        // reset while polling
        clear_tb(); busy_cfg = 12;
        send_req(7'h50, 1'b1, 8'd2);
        k = 0;
        while (!go_seen && k < 200) begin @(posedge PCLK); k++; end
        check("t6_go_seen", go_seen, 1);
        repeat (8) @(posedge PCLK);
        #1; k = 0;
        while (!PSELx && k < 20) begin @(posedge PCLK); #1; k++; end
        check("t6_psel_before", PSELx, 1);
        nd = n_done;
        #1 PRESETn = 1'b0;
        #1;
        check("t6_psel_rst", PSELx, 0);
        check("t6_penable_rst", PENABLE, 0);
        check("t6_req_ready_rst", req_ready, 1);
        repeat (3) @(negedge PCLK);
        clear_tb(); wr_q.delete();
        PRESETn = 1'b1;
        repeat (30) @(posedge PCLK);
        check("t6_no_done", n_done, nd);
        busy_cfg = 3; wr_q = '{8'h11, 8'h22};
        send_req(7'h50, 1'b0, 8'd2);
        wait_done("t6b", e);
        check("t6b_err", e, 0);
        exp_q = '{'h0F8, 'h4A0, 'h211, 'h222, 'h0FC, 'h0F8};
        check_trace("t6b", exp_q);
        check("t6b_wr_pulses", n_wr_pulses, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
